blastn_hit_merger: RTL
======================

# blastn_hit_merger

Parametrised hit-collection stage for the BLASTN datapath. It merges hit records (query address, subject address, length) from `N_CH` systolic-array lanes into one first-word-fall-through summary FIFO, rebasing each lane's query address into global query coordinates. It filters short hits against a runtime threshold and supports backpressure or drop-on-full modes. It sits between the per-lane hit-to-FIFO extractors and the ungapped-extension / host read-out logic, replacing the single-lane summary FIFO path.

## Interface
- `N_CH`, 4, number of hit lanes (≥2)
- `ADDR_W`, 8, width of query/subject address fields
- `LEN_W`, 8, width of hit length field (encoded as length−1, as produced upstream)
- `SEG_LEN`, 32, query segment length covered by one lane
- `DEPTH`, 16, FIFO entries (power of two, ≥4)
- `CNT_W`, 8, width of statistics counters
- `DROP_ON_FULL`, 0, 0 = backpressure lanes when full; 1 = accept and discard when full
- `array_clk` in 1 — single clock, all logic rising-edge
- `reset` in 1 — asynchronous, active-low
- `clear` in 1 — synchronous clear of FIFO, arbiter and counters
- `min_length` in LEN_W — hits with `hit_length < min_length` are discarded
- `hit_valid` in N_CH — per-lane record valid
- `hit_ready` out N_CH — per-lane record consumed this cycle
- `hit_q_addr` in N_CH*ADDR_W — lane-local query address, lane i at bits [i*ADDR_W +: ADDR_W]
- `hit_s_addr` in N_CH*ADDR_W — subject address
- `hit_length` in N_CH*LEN_W — hit length field
- `read_HSP` in 1 — pop head entry
- `out_valid` out 1 — head entry valid (= not empty)
- `out_q_addr`, `out_s_addr` out ADDR_W — head entry addresses, global query coordinates
- `out_length` out LEN_W — head entry length field
- `out_channel` out $clog2(N_CH) — source lane of head entry
- `fifo_count` out $clog2(DEPTH)+1 — occupancy
- `fifo_full`, `fifo_empty` out 1
- `filt_count`, `drop_count` out CNT_W — saturating counts of filtered and full-dropped hits

## Operation
- Lane i is eligible when `hit_valid[i]` is set and `hit_length[i] >= min_length` (unsigned).
- Filtered lanes (`valid` and `length < min_length`) get `hit_ready` the same cycle regardless of FIFO state. All such lanes are consumed in parallel. `filt_count` increments by the number filtered, saturating at 2^CNT_W−1.
- Round-robin arbiter with pointer `rr`. The grant goes to the lowest eligible index ≥ `rr`, wrapping. After a grant that is written or dropped, `rr` = grant+1 mod N_CH. With no grant, `rr` holds.
- Write allowed when `!fifo_full || (read_HSP && out_valid)`.
- DROP_ON_FULL=0: `hit_ready[grant]` is set only when a write is allowed. Non-granted eligible lanes hold their records.
- DROP_ON_FULL=1: `hit_ready[grant]` is always set. If no write is allowed, the record is discarded and `drop_count` increments (saturating).
- Stored query address = `hit_q_addr[g] + (N_CH−1−g)*SEG_LEN`, truncated to ADDR_W (wraps modulo 2^ADDR_W). Subject address and length are stored unchanged. `out_channel` = g.
- The pop occurs when `read_HSP && out_valid`. `read_HSP` while empty is ignored.
- `hit_ready` is combinational from `hit_valid`, `hit_length`, `min_length`, `rr`, FIFO state and `read_HSP`.

## Timing
- Reset (async assert, `reset`=0) and `clear` (sync) do the following:
  - set pointers, `fifo_count`, `rr`, `filt_count` and `drop_count` to 0;
  - set `fifo_empty`=1, `fifo_full`=0, `out_valid`=0;
  - set `out_q_addr`, `out_s_addr`, `out_length` and `out_channel` to 0;
  - force `hit_ready`=0.
- `clear` overrides any write or pop in the same cycle.
- Latency: a record accepted at edge k is visible on `out_*` with `out_valid`=1 after edge k (next cycle) when the FIFO was empty.
- Pop at edge k presents the next entry after edge k. `fifo_count` updates at the same edge.
- Simultaneous write and pop:
  - count unchanged;
  - allowed when full;
  - when count=1, the new entry becomes head after the edge.
- Throughput: 1 write and 1 pop per cycle.
- Reset deasserted mid-stream: no records are accepted until the first edge after deassertion.

## Test plan
- Reset/single hit: N_CH=4, lane 1 presents q=5, s=9, len=3, min_length=0. Required: `hit_ready[1]`=1; the next cycle shows `out_q_addr`=69, `out_s_addr`=9, `out_length`=3, `out_channel`=1, `fifo_count`=1.
- Round-robin fairness: all 4 lanes are held valid, with no reads. Required: grant order is 0,1,2,3,0. Lane 3 query address is unrebased; lane 0 gets +96.
- Filter: `min_length`=4, lane 2 len=3, lane 0 len=4, same cycle. Required: both readies are 1, only lane 0 is stored, `filt_count`=1.
- Full, backpressure: DROP_ON_FULL=0, 16 hits are written, then lane 0 is valid with no read. Required: `fifo_full`=1 and `hit_ready`=0. Asserting `read_HSP` the same cycle gives `hit_ready[0]`=1 with count staying 16.
- Full, drop: DROP_ON_FULL=1 with the FIFO full, 3 more hits arrive without reads. Required: readies are 1, `drop_count`=3, contents unchanged.
- Wrap and clear: lane 0 q=250, SEG_LEN=32, N_CH=4. Required: `out_q_addr`=(250+96) mod 256=90. A subsequent `clear` with `read_HSP`=1 and a write pending gives empty FIFO, counters 0, `rr`=0.

Source files
------------

// File: rtl/blastn_hit_merger.sv
// BLASTN hit merger: round-robin collection of per-lane hit records into
// one first-word-fall-through summary FIFO with length filtering.
module blastn_hit_merger #(
    parameter int N_CH         = 4,
    parameter int ADDR_W       = 8,
    parameter int LEN_W        = 8,
    parameter int SEG_LEN      = 32,
    parameter int DEPTH        = 16,
    parameter int CNT_W        = 8,
    parameter int DROP_ON_FULL = 0,
    localparam int CH_W        = $clog2(N_CH),
    localparam int AW          = $clog2(DEPTH),
    localparam int CW          = AW + 1
) (
    input  logic                     array_clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic [LEN_W-1:0]         min_length,
    input  logic [N_CH-1:0]          hit_valid,
    output logic [N_CH-1:0]          hit_ready,
    input  logic [N_CH*ADDR_W-1:0]   hit_q_addr,
    input  logic [N_CH*ADDR_W-1:0]   hit_s_addr,
    input  logic [N_CH*LEN_W-1:0]    hit_length,
    input  logic                     read_HSP,
    output logic                     out_valid,
    output logic [ADDR_W-1:0]        out_q_addr,
    output logic [ADDR_W-1:0]        out_s_addr,
    output logic [LEN_W-1:0]         out_length,
    output logic [CH_W-1:0]          out_channel,
    output logic [CW-1:0]            fifo_count,
    output logic                     fifo_full,
    output logic                     fifo_empty,
    output logic [CNT_W-1:0]         filt_count,
    output logic [CNT_W-1:0]         drop_count
);

    localparam int SUM_W = CNT_W + $clog2(N_CH + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [ADDR_W-1:0] r_mem_q   [DEPTH];
    logic [ADDR_W-1:0] r_mem_s   [DEPTH];
    logic [LEN_W-1:0]  r_mem_len [DEPTH];
    logic [CH_W-1:0]   r_mem_ch  [DEPTH];

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic [CH_W-1:0]  r_rr;
    logic [CNT_W-1:0] r_filt;
    logic [CNT_W-1:0] r_drop;

    logic [N_CH-1:0]   w_filt;
    logic [N_CH-1:0]   w_elig;
    logic              w_gnt_vld;
    logic [CH_W-1:0]   w_gnt;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr_ok;
    logic              w_active;
    logic              w_wr;
    logic              w_drop;
    logic              w_adv;
    logic [ADDR_W-1:0] w_q_raw;
    logic [ADDR_W-1:0] w_q_reb;
    logic [ADDR_W-1:0] w_s_raw;
    logic [LEN_W-1:0]  w_len_raw;
    logic [SUM_W-1:0]  w_nfilt;
    logic [SUM_W-1:0]  w_filt_sum;
    logic [CNT_W-1:0]  w_filt_nxt;
    logic [CH_W-1:0]   w_rr_nxt;

    always_comb begin
        w_filt = '0;
        w_elig = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit_valid[i]) begin
                if (hit_length[i*LEN_W +: LEN_W] < min_length)
                    w_filt[i] = 1'b1;
                else
                    w_elig[i] = 1'b1;
            end
        end
    end

    // Scan from the highest offset down so the nearest lane at/after rr wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_vld = 1'b0;
        w_gnt     = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            idx = int'(r_rr) + k;
            if (idx >= N_CH)
                idx = idx - N_CH;
            if (w_elig[idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt     = CH_W'(idx);
            end
        end
    end

    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_pop    = read_HSP && !w_empty;
    assign w_wr_ok  = !w_full || w_pop;
    assign w_active = reset && !clear;
    assign w_wr     = w_active && w_gnt_vld && w_wr_ok;
    assign w_drop   = w_active && w_gnt_vld && !w_wr_ok && (DROP_ON_FULL != 0);
    assign w_adv    = w_wr || w_drop;

    always_comb begin
        hit_ready = '0;
        if (w_active) begin
            hit_ready = w_filt;
            if (w_gnt_vld && ((DROP_ON_FULL != 0) || w_wr_ok))
                hit_ready[w_gnt] = 1'b1;
        end
    end

    // Lane g covers query segment N_CH-1-g; rebase into global coordinates.
    always_comb begin
        int off;
        w_q_raw   = hit_q_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
        w_s_raw   = hit_s_addr[int'(w_gnt)*ADDR_W +: ADDR_W];
        w_len_raw = hit_length[int'(w_gnt)*LEN_W +: LEN_W];
        off       = (N_CH - 1 - int'(w_gnt)) * SEG_LEN;
        w_q_reb   = w_q_raw + ADDR_W'(off);
    end

    always_comb begin
        w_nfilt = '0;
        for (int i = 0; i < N_CH; i++)
            w_nfilt = w_nfilt + SUM_W'(w_filt[i]);
        w_filt_sum = SUM_W'(r_filt) + w_nfilt;
        if (w_filt_sum > SUM_W'(CNT_MAX))
            w_filt_nxt = CNT_MAX;
        else
            w_filt_nxt = CNT_W'(w_filt_sum);
    end

    assign w_rr_nxt = (int'(w_gnt) == N_CH - 1) ? '0 : w_gnt + CH_W'(1);

    always_ff @(posedge array_clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= '0;
            r_filt   <= '0;
            r_drop   <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_rr     <= '0;
            r_filt   <= '0;
            r_drop   <= '0;
        end else begin
            if (w_wr)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_wr && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_wr && w_pop)
                r_count <= r_count - CW'(1);
            if (w_adv)
                r_rr <= w_rr_nxt;
            r_filt <= w_filt_nxt;
            if (w_drop && (r_drop != CNT_MAX))
                r_drop <= r_drop + CNT_W'(1);
        end
    end

    // Storage needs no reset; the head is masked to zero while empty.
    always_ff @(posedge array_clk) begin
        if (w_wr) begin
            r_mem_q[r_wr_ptr]   <= w_q_reb;
            r_mem_s[r_wr_ptr]   <= w_s_raw;
            r_mem_len[r_wr_ptr] <= w_len_raw;
            r_mem_ch[r_wr_ptr]  <= w_gnt;
        end
    end

    assign out_valid   = !w_empty;
    assign out_q_addr  = w_empty ? '0 : r_mem_q[r_rd_ptr];
    assign out_s_addr  = w_empty ? '0 : r_mem_s[r_rd_ptr];
    assign out_length  = w_empty ? '0 : r_mem_len[r_rd_ptr];
    assign out_channel = w_empty ? '0 : r_mem_ch[r_rd_ptr];
    assign fifo_count  = r_count;
    assign fifo_full   = w_full;
    assign fifo_empty  = w_empty;
    assign filt_count  = r_filt;
    assign drop_count  = r_drop;

endmodule
